// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO operand-link receiver: default word width and FSM states.
package sipo_pkg;

  localparam int SIPO_WIDTH = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_out_fifo.sv
// Two-entry in-order word buffer between the serial deframer and the MAC operand path.
module sipo_out_fifo #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       level;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == 2'd2);
  assign empty   = (level == 2'd0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is deliberately not reset; dout is forced to 0 while empty, so stale
  // contents are never visible and the array maps onto plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/register_sipo_receiver.sv
// Serial-in parallel-out receiver: deframes MSB-first words and buffers them for a
// valid/ready consumer, flagging any completed word lost to a full buffer.
module register_sipo_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             reg_clk_i,
  input  logic             reg_reset_i,
  input  logic             sdi_i,
  input  logic             sdi_en_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] pdo_o,
  output logic             pdo_valid_o,
  input  logic             pdo_ready_i,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-2:0] shreg;   // leading bits of the frame; the final bit arrives live
  logic [WIDTH-1:0] word;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign word = {shreg, sdi_i};
  assign push = (state == SHIFT) && sdi_en_i && !start_i && (bit_cnt == CW'(WIDTH - 1));
  assign pop  = pdo_valid_o && pdo_ready_i;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge reg_clk_i or posedge reg_reset_i) begin
    if (reg_reset_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (sdi_en_i) begin
      if (start_i) begin
        // A start always begins a fresh frame, abandoning any partial word.
        state   <= SHIFT;
        bit_cnt <= CW'(1);
        shreg   <= (WIDTH-1)'(sdi_i);
      end else if (state == SHIFT) begin
        shreg <= word[WIDTH-2:0];
        if (push) begin
          state   <= IDLE;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge reg_clk_i or posedge reg_reset_i) begin
    if (reg_reset_i)               overrun_o <= 1'b0;
    else if (push && full && !pop) overrun_o <= 1'b1;
  end

  sipo_out_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk   (reg_clk_i),
    .rst   (reg_reset_i),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .dout  (pdo_o),
    .full  (full),
    .empty (empty)
  );

  assign pdo_valid_o = !empty;
  assign busy_o      = (state == SHIFT);

endmodule
